param_connection_block: RTL and testbench

//  Parametrised next-generation FPGA connection block between two logic blocks (LB1, LB2) and a
//  W-track routing channel entering from both ends (CB1, CB2). Routing is held in a double-buffered

---
 rtl/param_connection_block.sv | 189 ++++++++++++++++++
 tb/tb_param_connection_block.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/param_connection_block.sv
// param_connection_block
//   Connection block between two logic blocks (LB1, LB2) and a W-track channel entering from both
//   ends (CB1, CB2). Routing selects live in a double-buffered serial configuration chain: a frame
//   is shifted into a shadow register and then committed atomically into the active register.
//
//   Optional build macro: CB_OUTREG_EN registers all four routed output buses (one cycle latency).
//
// Ports
//   clk_i        fabric/config clock
//   rst_i        synchronous active-high reset
//   lb1_i/lb2_i  [I-1:0] pins from LB1/LB2 that can drive tracks
//   cb1_i/cb2_i  [W-1:0] tracks arriving at the CB1/CB2 end
//   lb1_o/lb2_o  [O-1:0] pins to LB1/LB2 fed from tracks
//   cb1_o/cb2_o  [W-1:0] tracks leaving the CB1/CB2 end
//   ce_i         config shift enable
//   sin_i        config serial in
//   sout_o       config serial out (shadow MSB), for daisy-chaining
//   commit_i     copy shadow frame into active config
//   cfg_done_o   one-cycle pulse after an accepted commit
//   cfg_err_o    sticky flag, a commit arrived before a full frame was shifted
module param_connection_block #(
  parameter int unsigned W = 5,
  parameter int unsigned I = 1,
  parameter int unsigned O = 6
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [I-1:0] lb1_i,
  input  logic [I-1:0] lb2_i,
  input  logic [W-1:0] cb1_i,
  input  logic [W-1:0] cb2_i,
  output logic [O-1:0] lb1_o,
  output logic [O-1:0] lb2_o,
  output logic [W-1:0] cb1_o,
  output logic [W-1:0] cb2_o,
  input  logic         ce_i,
  input  logic         sin_i,
  output logic         sout_o,
  input  logic         commit_i,
  output logic         cfg_done_o,
  output logic         cfg_err_o
);

  localparam int unsigned SelT    = $clog2(1 + 2 * I);
  localparam int unsigned SelL    = $clog2(2 * W + 1);
  localparam int unsigned TBits   = 2 * W * SelT;
  localparam int unsigned CfgBits = TBits + 2 * O * SelL;
  localparam int unsigned CntW    = $clog2(CfgBits + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(CfgBits);

  typedef enum logic [1:0] {StIdle, StLoading, StReady} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [CfgBits-1:0]  shift_q, shift_d;
  logic [CfgBits-1:0]  active_q, active_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  // Config chain and FSM
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    active_d = active_q;
    done_d   = 1'b0;
    err_d    = err_q;

    // Commit sees the pre-shift shadow and count, so it is resolved before the shift.
    if (commit_i) begin
      if (state_q == StReady) begin
        active_d = shift_q;
        cnt_d    = '0;
        done_d   = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end

    if (ce_i) begin
      shift_d = {shift_q[CfgBits-2:0], sin_i};
      if (cnt_d != CntFull) begin
        cnt_d = cnt_d + 1'b1;
      end
    end

    unique case (1'b1)
      (cnt_d == '0):     state_d = StIdle;
      (cnt_d == CntFull): state_d = StReady;
      default:           state_d = StLoading;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      shift_q  <= '0;
      active_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      active_q <= active_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign sout_o     = shift_q[CfgBits-1];
  assign cfg_done_o = done_q;
  assign cfg_err_o  = err_q;

  // Track select: 0 passes the opposite end through, 1..I picks LB1, I+1..2I picks LB2.
  function automatic logic track_mux(input logic [SelT-1:0] sel, input logic pass,
                                     input logic [I-1:0] a, input logic [I-1:0] b);
    logic r;
    r = 1'b0;
    if (sel == '0) r = pass;
    for (int k = 0; k < int'(I); k++) begin
      if (int'(sel) == k + 1) r = a[k];
      if (int'(sel) == int'(I) + 1 + k) r = b[k];
    end
    return r;
  endfunction

  // Pin select: 0 drives low, 1..W picks CB1 tracks, W+1..2W picks CB2 tracks.
  function automatic logic pin_mux(input logic [SelL-1:0] sel, input logic [W-1:0] a,
                                   input logic [W-1:0] b);
    logic r;
    r = 1'b0;
    for (int k = 0; k < int'(W); k++) begin
      if (int'(sel) == k + 1) r = a[k];
      if (int'(sel) == int'(W) + 1 + k) r = b[k];
    end
    return r;
  endfunction

  logic [W-1:0] cb1_rt, cb2_rt;
  logic [O-1:0] lb1_rt, lb2_rt;

  always_comb begin
    cb1_rt = '0;
    cb2_rt = '0;
    lb1_rt = '0;
    lb2_rt = '0;
    for (int t = 0; t < int'(W); t++) begin
      // Direction 0 heads toward CB2, direction 1 toward CB1.
      cb2_rt[t] = track_mux(active_q[t*SelT +: SelT], cb1_i[t], lb1_i, lb2_i);
      cb1_rt[t] = track_mux(active_q[(int'(W)+t)*SelT +: SelT], cb2_i[t], lb1_i, lb2_i);
    end
    for (int j = 0; j < int'(O); j++) begin
      lb1_rt[j] = pin_mux(active_q[TBits + j*SelL +: SelL], cb1_i, cb2_i);
      lb2_rt[j] = pin_mux(active_q[TBits + (int'(O)+j)*SelL +: SelL], cb1_i, cb2_i);
    end
  end

`ifdef CB_OUTREG_EN
  logic [W-1:0] cb1_q, cb2_q;
  logic [O-1:0] lb1_q, lb2_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cb1_q <= '0;
      cb2_q <= '0;
      lb1_q <= '0;
      lb2_q <= '0;
    end else begin
      cb1_q <= cb1_rt;
      cb2_q <= cb2_rt;
      lb1_q <= lb1_rt;
      lb2_q <= lb2_rt;
    end
  end

  assign cb1_o = cb1_q;
  assign cb2_o = cb2_q;
  assign lb1_o = lb1_q;
  assign lb2_o = lb2_q;
`else
  assign cb1_o = cb1_rt;
  assign cb2_o = cb2_rt;
  assign lb1_o = lb1_rt;
  assign lb2_o = lb2_rt;
`endif

endmodule

// File: tb/tb_param_connection_block.sv
// Testbench for param_connection_block: directed steps plus random traffic, checked against a
// frame-level reference model (queue of shifted bits, decoded integer select fields).
module tb_param_connection_block;

  localparam int W       = 5;
  localparam int I       = 1;
  localparam int O       = 6;
  localparam int SelT    = $clog2(1 + 2 * I);
  localparam int SelL    = $clog2(2 * W + 1);
  localparam int TBits   = 2 * W * SelT;
  localparam int CfgBits = TBits + 2 * O * SelL;

  logic         clk = 1'b0;
  logic         rst, ce, sin, commit;
  logic [I-1:0] lb1, lb2;
  logic [W-1:0] cb1, cb2;
  logic [O-1:0] lb1_o, lb2_o;
  logic [W-1:0] cb1_o, cb2_o;
  logic         sout, done, err;

  always #5 clk = ~clk;

  param_connection_block #(.W(W), .I(I), .O(O)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .lb1_i      (lb1),
    .lb2_i      (lb2),
    .cb1_i      (cb1),
    .cb2_i      (cb2),
    .lb1_o      (lb1_o),
    .lb2_o      (lb2_o),
    .cb1_o      (cb1_o),
    .cb2_o      (cb2_o),
    .ce_i       (ce),
    .sin_i      (sin),
    .sout_o     (sout),
    .commit_i   (commit),
    .cfg_done_o (done),
    .cfg_err_o  (err)
  );

  // Reference model state
  bit q[$];                 // most recent CfgBits shifted bits, oldest at front
  int m_cnt;
  bit m_act[CfgBits];
  bit m_err, m_done;
  bit fr[CfgBits];          // frame under construction for directed loads
  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int fld(input int lo, input int n);
    int v = 0;
    for (int b = 0; b < n; b++) v += int'(m_act[lo + b]) << b;
    return v;
  endfunction

  function automatic logic trk(input int v, input logic pass);
    if (v == 0) return pass;
    if (v <= I) return lb1[v-1];
    if (v <= 2 * I) return lb2[v-I-1];
    return 1'b0;
  endfunction

  function automatic logic pin(input int v);
    if (v == 0) return 1'b0;
    if (v <= W) return cb1[v-1];
    if (v <= 2 * W) return cb2[v-W-1];
    return 1'b0;
  endfunction

  task automatic calc(output logic [W-1:0] c1, output logic [W-1:0] c2,
                      output logic [O-1:0] l1, output logic [O-1:0] l2);
    for (int t = 0; t < W; t++) begin
      c2[t] = trk(fld(t * SelT, SelT), cb1[t]);
      c1[t] = trk(fld((W + t) * SelT, SelT), cb2[t]);
    end
    for (int j = 0; j < O; j++) begin
      l1[j] = pin(fld(TBits + j * SelL, SelL));
      l2[j] = pin(fld(TBits + (O + j) * SelL, SelL));
    end
  endtask

  task automatic step(input bit r, input bit c, input bit s, input bit cm);
    logic [W-1:0] e1, e2;
    logic [O-1:0] f1, f2;
    rst = r; ce = c; sin = s; commit = cm;
`ifdef CB_OUTREG_EN
    calc(e1, e2, f1, f2);
    if (r) begin e1 = '0; e2 = '0; f1 = '0; f2 = '0; end
`endif
    @(posedge clk);
    if (r) begin
      q.delete(); m_cnt = 0; m_err = 0; m_done = 0;
      for (int k = 0; k < CfgBits; k++) m_act[k] = 0;
    end else begin
      m_done = 0;
      if (cm) begin
        if (m_cnt == CfgBits) begin
          for (int k = 0; k < CfgBits; k++) m_act[k] = q[q.size() - 1 - k];
          m_cnt = 0; m_done = 1;
        end else m_err = 1;
      end
      if (c) begin
        q.push_back(s);
        if (q.size() > CfgBits) void'(q.pop_front());
        if (m_cnt < CfgBits) m_cnt++;
      end
    end
`ifndef CB_OUTREG_EN
    calc(e1, e2, f1, f2);
`endif
    #1;
    chk("cb1_o", cb1_o, e1);
    chk("cb2_o", cb2_o, e2);
    chk("lb1_o", lb1_o, f1);
    chk("lb2_o", lb2_o, f2);
    chk("sout", sout, (q.size() == CfgBits) ? q[0] : 1'b0);
    chk("cfg_done", done, m_done);
    chk("cfg_err", err, m_err);
  endtask

  task automatic put(input int lo, input int n, input int v);
    for (int b = 0; b < n; b++) fr[lo + b] = bit'((v >> b) & 1);
  endtask

  task automatic clr_frame();
    for (int k = 0; k < CfgBits; k++) fr[k] = 0;
  endtask

  task automatic load_frame();
    for (int k = CfgBits - 1; k >= 0; k--) step(0, 1, fr[k], 0);
  endtask

  task automatic shift_rand(input int n);
    for (int k = 0; k < n; k++) step(0, 1, 1'($urandom), 0);
  endtask

  task automatic rand_data();
    lb1 = I'($urandom); lb2 = I'($urandom);
    cb1 = W'($urandom); cb2 = W'($urandom);
  endtask

  initial begin
    rst = 1; ce = 0; sin = 0; commit = 0;
    lb1 = '0; lb2 = '0; cb1 = '0; cb2 = '0;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);

    // Unconfigured: pass-through, pins low
    cb1 = 5'h15; cb2 = 5'h0A;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("t1_cb2_pass", cb2_o, 5'h15);
    chk("t1_cb1_pass", cb1_o, 5'h0A);

    // T[0][2]=1 (LB1 onto track 2 toward CB2), L[1][3]=7 (CB2 track 1 to LB2 pin 3)
    clr_frame();
    put(2 * SelT, SelT, 1);
    put(TBits + (O + 3) * SelL, SelL, 7);
    load_frame();
    step(0, 0, 0, 1);
    lb1 = 1'b1; cb2 = 5'b00010; cb1 = 5'h0C;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("t2_cb2_lb1", cb2_o[2], 1'b1);
    chk("t2_lb2_pin3", lb2_o[3], 1'b1);
    chk("t2_cb1_pass", cb1_o, 5'b00010);

    // Short frame commit rejected, then completed frame accepted
    rand_data();
    shift_rand(40);
    step(0, 0, 0, 1);
    shift_rand(28);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);

    // CE with COMMIT: pre-shift frame committed; 67 further shifts needed
    step(1, 0, 0, 0);
    shift_rand(CfgBits);
    step(0, 1, 1'($urandom), 1);
    shift_rand(66);
    step(0, 0, 0, 1);
    shift_rand(1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);

    // Overflow shifting: excess bits spill on sout, last CfgBits committed
    step(1, 0, 0, 0);
    shift_rand(CfgBits + 8);
    step(0, 0, 0, 1);
    for (int k = 0; k < 4; k++) begin rand_data(); step(0, 0, 0, 0); end

    // Out-of-range selects plus a few valid ones
    clr_frame();
    put(0, SelT, 3);
    put((W + 4) * SelT, SelT, 3);
    put(SelT, SelT, 2);
    put(TBits, SelL, 15);
    put(TBits + (2 * O - 1) * SelL, SelL, 11);
    put(TBits + SelL, SelL, 10);
    load_frame();
    step(0, 0, 0, 1);
    for (int k = 0; k < 8; k++) begin
      rand_data();
      step(0, 0, 0, 0);
    end
    lb1 = '1; lb2 = '1; cb1 = '1; cb2 = '1;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("t6_cb2_oor", cb2_o[0], 1'b0);
    chk("t6_cb1_oor", cb1_o[4], 1'b0);
    chk("t6_lb1_oor", lb1_o[0], 1'b0);
    chk("t6_lb2_oor", lb2_o[O-1], 1'b0);

    // Random traffic
    for (int k = 0; k < 1500; k++) begin
      rand_data();
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 8), 1'($urandom),
           ($urandom_range(0, 59) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
